signed_divider: RTL

SIGNED_DIVIDER -- requirements
Module: signed_divider

---
 rtl/arith_pkg.sv | 22 ++
 rtl/abs_unit.sv | 18 +
 rtl/signed_divider.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic package: state encodings for the iterative
// divider and multiplier blocks of this library.
package arith_pkg;

  // Restoring divider sequence: one SHIFT/CALC pair per quotient bit,
  // then sign fix-up and a result-register stage.
  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_SHIFT,
    DIV_CALC,
    DIV_FIX,
    DIV_FINISH
  } div_state_t;

  // Shift-add multiplier sequence.
  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_FINISH
  } mul_state_t;

endpackage

// File: rtl/abs_unit.sv
// Combinational two's-complement conditional negate.
// With negate tied to the operand's sign bit it yields the N-bit unsigned
// magnitude (the most-negative value maps to 2^(N-1), read as unsigned).
// Ports:
//   operand - N-bit input value
//   negate  - 1: result = -operand, 0: result = operand
//   result  - N-bit output
module abs_unit #(
  parameter int N = 5
) (
  input  logic [N-1:0] operand,
  input  logic         negate,
  output logic [N-1:0] result
);

  assign result = negate ? (~operand + 1'b1) : operand;

endmodule

// File: rtl/signed_divider.sv
// Iterative signed restoring divider. Divides operand magnitudes one bit
// per SHIFT/CALC pair, then fixes signs: quotient truncates toward zero,
// remainder carries the dividend's sign.
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-low reset
//   start        - launch request, sampled only while idle
//   dividend     - N-bit signed numerator
//   divisor      - N-bit signed denominator
//   quotient     - N-bit signed result, held between done pulses
//   remainder    - N-bit signed result, held between done pulses
//   done         - one-cycle pulse when results update
//   busy         - high whenever an operation is in flight
//   div_by_zero  - last result came from a zero divisor
//   overflow     - last result was -2^(N-1) / -1 (quotient wrapped)
module signed_divider #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero,
  output logic         overflow
);

  import arith_pkg::*;

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(N);
  localparam logic [N-1:0]  MOST_NEG   = {1'b1, {(N-1){1'b0}}};

  div_state_t state, state_nxt;

  logic          sign_a, sign_b;
  logic [N-1:0]  dmag_r;
  logic [N-1:0]  quo_r;
  // One extra bit: the shifted partial remainder can reach 2*|divisor|-1.
  logic [N:0]    rem_r;
  logic [CW-1:0] count_r;
  logic          dz_r, ovf_r;

  logic [N-1:0]  mag_a, mag_b, quo_fix, rem_fix;
  logic [N:0]    trial;

  abs_unit #(.N(N)) u_abs_dividend (
    .operand (dividend),
    .negate  (dividend[N-1]),
    .result  (mag_a)
  );

  abs_unit #(.N(N)) u_abs_divisor (
    .operand (divisor),
    .negate  (divisor[N-1]),
    .result  (mag_b)
  );

  abs_unit #(.N(N)) u_fix_quotient (
    .operand (quo_r),
    .negate  (sign_a ^ sign_b),
    .result  (quo_fix)
  );

  abs_unit #(.N(N)) u_fix_remainder (
    .operand (rem_r[N-1:0]),
    .negate  (sign_a),
    .result  (rem_fix)
  );

  assign trial = rem_r - {1'b0, dmag_r};
  assign busy  = (state != DIV_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: the next-state value is defaulted before the case so that every
  // path assigns it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE:   if (start) state_nxt = (divisor == '0) ? DIV_FINISH : DIV_SHIFT;
      DIV_SHIFT:  state_nxt = DIV_CALC;
      DIV_CALC:   state_nxt = (count_r != '0) ? DIV_SHIFT : DIV_FIX;
      DIV_FIX:    state_nxt = DIV_FINISH;
      DIV_FINISH: state_nxt = DIV_IDLE;
      default:    state_nxt = DIV_IDLE;
    endcase
  end

  // NOTE: there is no storage array here, so every datapath register gets
  // a reset value; an aborted operation leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dmag_r      <= '0;
      quo_r       <= '0;
      rem_r       <= '0;
      count_r     <= '0;
      dz_r        <= 1'b0;
      ovf_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= (state == DIV_FINISH);
      case (state)
        DIV_IDLE: begin
          if (start) begin
            sign_a <= dividend[N-1];
            sign_b <= divisor[N-1];
            dz_r   <= (divisor == '0);
            ovf_r  <= (dividend == MOST_NEG) && (divisor == '1);
            if (divisor == '0) begin
              // Zero divisor bypasses the iteration: results are preloaded
              // here and copied out by FINISH.
              quo_r   <= '1;
              rem_r   <= {1'b0, dividend};
              dmag_r  <= '0;
              count_r <= '0;
            end else begin
              quo_r   <= mag_a;
              rem_r   <= '0;
              dmag_r  <= mag_b;
              count_r <= COUNT_INIT;
            end
          end
        end
        DIV_SHIFT: begin
          {rem_r, quo_r} <= {rem_r[N-1:0], quo_r, 1'b0};
          count_r        <= count_r - 1'b1;
        end
        DIV_CALC: begin
          // Non-negative trial: subtraction fits, keep it and set the bit.
          // Otherwise the partial remainder is left untouched (restore).
          if (!trial[N]) begin
            rem_r    <= trial;
            quo_r[0] <= 1'b1;
          end
        end
        DIV_FIX: begin
          quo_r <= quo_fix;
          rem_r <= {1'b0, rem_fix};
        end
        DIV_FINISH: begin
          quotient    <= quo_r;
          remainder   <= rem_r[N-1:0];
          div_by_zero <= dz_r;
          overflow    <= ovf_r;
        end
        default: ;
      endcase
    end
  end

endmodule
